// File: rtl/pps_tx_scheduler.sv
// rtl/pps_tx_scheduler.sv - time-triggered TX scheduler on a PPS-disciplined UTC timebase
module pps_tx_scheduler #(
  parameter int UTC_SECONDS_WIDTH       = 6,
  parameter int COUNT_LAST_SECOND_WIDTH = 26,
  parameter int NOMINAL_CYCLES_PER_SEC  = 61_440_000,
  parameter int MARGIN                  = 5,
  parameter int TRIG_PULSE_CYCLES       = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_pps,
  input  logic [UTC_SECONDS_WIDTH-1:0]       i_gps_utc_sec,
  input  logic                               i_sched_valid,
  output logic                               o_sched_ready,
  input  logic [UTC_SECONDS_WIDTH-1:0]       i_sched_utc_sec,
  input  logic [COUNT_LAST_SECOND_WIDTH-1:0] i_sched_clk_count,
  input  logic                               i_cancel,
  output logic                               o_tx_trigger,
  output logic                               o_done,
  output logic                               o_missed,
  output logic                               o_rejected,
  output logic                               o_armed,
  output logic                               o_synced
);

  localparam int UW = UTC_SECONDS_WIDTH;
  localparam int CW = COUNT_LAST_SECOND_WIDTH;
  localparam int PW = $clog2(TRIG_PULSE_CYCLES + 1);

  localparam logic [CW-1:0] CNT_FAB_AT = CW'(NOMINAL_CYCLES_PER_SEC + MARGIN - 1);
  localparam logic [CW-1:0] CNT_NOM    = CW'(NOMINAL_CYCLES_PER_SEC);
  localparam logic [CW-1:0] CNT_MARGIN = CW'(MARGIN);
  localparam logic [CW-1:0] CNT_ALIGN  = CW'(100);
  localparam logic [UW-1:0] SEC_MAX    = UW'(59);
  localparam logic [PW-1:0] PULSE_LAST = PW'(TRIG_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  // Timebase state
  logic          r_pps_meta;
  logic          r_pps_sync;
  logic          r_pps_prev;
  logic          r_started;
  logic          r_aligned;
  logic [CW-1:0] r_cnt;
  logic [UW-1:0] r_sec;

  // Scheduler state
  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_pulse_cnt;
  logic [UW-1:0] r_tgt_sec;
  logic [CW-1:0] r_tgt_cnt;
  logic          r_rejected;

  logic w_pps_rise;
  logic w_fab_pps;
  logic w_pps_event;
  logic w_align;
  logic w_synced;
  logic w_ready;
  logic w_accept;
  logic w_req_bad;
  logic w_sec_hit;
  logic w_match;
  logic w_late;

  assign w_pps_rise  = r_pps_sync & ~r_pps_prev;
  // A missing PPS is replaced MARGIN cycles late; the count restarts at MARGIN
  // so the fabricated second keeps the nominal length.
  assign w_fab_pps   = r_started & ~w_pps_rise & (r_cnt == CNT_FAB_AT);
  assign w_pps_event = w_pps_rise | w_fab_pps;
  assign w_align     = ~r_aligned & (i_gps_utc_sec != '0) & (r_cnt >= CNT_ALIGN);
  assign w_synced    = r_started & r_aligned;
  assign w_ready     = w_synced & (r_state == S_IDLE);
  assign w_accept    = i_sched_valid & w_ready;
  assign w_req_bad   = (i_sched_utc_sec > SEC_MAX) | (i_sched_clk_count >= CNT_NOM);
  assign w_sec_hit   = (r_sec == r_tgt_sec);
  assign w_match     = w_sec_hit & (r_cnt == r_tgt_cnt);
  assign w_late      = w_sec_hit & ((r_cnt > r_tgt_cnt) | w_pps_event);

  // PPS synchroniser, in-second counter and UTC second tracking
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pps_meta <= 1'b0;
      r_pps_sync <= 1'b0;
      r_pps_prev <= 1'b0;
      r_started  <= 1'b0;
      r_aligned  <= 1'b0;
      r_cnt      <= '0;
      r_sec      <= '0;
    end else begin
      r_pps_meta <= i_pps;
      r_pps_sync <= r_pps_meta;
      r_pps_prev <= r_pps_sync;
      if (w_pps_rise) begin
        r_started <= 1'b1;
      end
      if (w_pps_rise) begin
        r_cnt <= '0;
      end else if (r_started) begin
        r_cnt <= w_fab_pps ? CNT_MARGIN : r_cnt + CW'(1);
      end
      if (w_align) begin
        r_sec     <= i_gps_utc_sec;
        r_aligned <= 1'b1;
      end else if (w_pps_event) begin
        r_sec <= (r_sec >= SEC_MAX) ? '0 : r_sec + UW'(1);
      end
    end
  end

  // Scheduler state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Target latch, trigger pulse width counter and reject strobe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pulse_cnt <= '0;
      r_tgt_sec   <= '0;
      r_tgt_cnt   <= '0;
      r_rejected  <= 1'b0;
    end else begin
      r_rejected  <= w_accept & w_req_bad;
      r_pulse_cnt <= (r_state == S_FIRE) ? r_pulse_cnt + PW'(1) : '0;
      if (w_accept && !w_req_bad) begin
        r_tgt_sec <= i_sched_utc_sec;
        r_tgt_cnt <= i_sched_clk_count;
      end
    end
  end

  // Next-state selection; match outranks the late check so a target that
  // coincides with a PPS edge still fires
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_req_bad) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (i_cancel) begin
          w_state_next = S_IDLE;
        end else if (w_match) begin
          w_state_next = S_FIRE;
        end else if (w_late) begin
          w_state_next = S_IDLE;
        end
      end
      S_FIRE: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_sched_ready = w_ready;
    o_synced      = w_synced;
    o_armed       = (r_state == S_ARMED);
    o_tx_trigger  = (r_state == S_FIRE);
    o_done        = (r_state == S_FIRE) && (r_pulse_cnt == '0);
    o_missed      = (r_state == S_ARMED) && !i_cancel && !w_match && w_late;
    o_rejected    = r_rejected;
  end

endmodule

// File: tb/tb_pps_tx_scheduler.sv
// tb/tb_pps_tx_scheduler.sv - scoreboard bench for pps_tx_scheduler
module tb_pps_tx_scheduler;

  localparam int UW   = 6;
  localparam int CW   = 26;
  localparam int NOM  = 1000;
  localparam int TRIG = 4;

  localparam int K_TRIG = 0;
  localparam int K_DONE = 1;
  localparam int K_FALL = 2;
  localparam int K_MISS = 3;
  localparam int K_REJ  = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic          pps;
  logic [UW-1:0] gps_utc_sec;
  logic          sched_valid;
  logic          sched_ready;
  logic [UW-1:0] sched_utc_sec;
  logic [CW-1:0] sched_clk_count;
  logic          cancel;
  logic          tx_trigger;
  logic          done;
  logic          missed;
  logic          rejected;
  logic          armed;
  logic          synced;

  int  cyc = 0;
  int  vectors = 0;
  int  errors = 0;
  int  pps_base = 20;
  int  pps_last = 54;
  int  pps_hold = 0;
  ev_t sb_q[$];

  pps_tx_scheduler #(
    .UTC_SECONDS_WIDTH(UW),
    .COUNT_LAST_SECOND_WIDTH(CW),
    .NOMINAL_CYCLES_PER_SEC(NOM),
    .MARGIN(5),
    .TRIG_PULSE_CYCLES(TRIG)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pps(pps),
    .i_gps_utc_sec(gps_utc_sec),
    .i_sched_valid(sched_valid),
    .o_sched_ready(sched_ready),
    .i_sched_utc_sec(sched_utc_sec),
    .i_sched_clk_count(sched_clk_count),
    .i_cancel(cancel),
    .o_tx_trigger(tx_trigger),
    .o_done(done),
    .o_missed(missed),
    .o_rejected(rejected),
    .o_armed(armed),
    .o_synced(synced)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_TRIG:  return "trig_rise";
      K_DONE:  return "done";
      K_FALL:  return "trig_fall";
      K_MISS:  return "missed";
      default: return "rejected";
    endcase
  endfunction

  // Expected time of day for the current cycle. pps raised after edge
  // pps_base-3 gives cnt==0 at cycle pps_base; sec 7 comes from gps alignment.
  // Beyond pps_last the second is fabricated: cnt runs 1000..1004, then 5.. .
  task automatic tnow(output int s, output int k);
    int d;
    int a;
    int r;
    int x;
    d = cyc - pps_base;
    if (d < 0) begin
      s = -1;
      k = -1;
    end else begin
      a = d / NOM;
      r = d % NOM;
      if (a > pps_last) begin
        x = d - NOM * (pps_last + 1);
        if (x < 5) begin
          a = pps_last;
          r = NOM + x;
        end else begin
          a = pps_last + 1 + (x - 5) / NOM;
          r = 5 + (x - 5) % NOM;
        end
      end
      s = (7 + a) % 60;
      k = r;
    end
  endtask

  function automatic int cyc_of(input int a, input int k);
    return pps_base + NOM * a + k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic expect_fire(input int c0, input int fall_at);
    push(K_TRIG, c0);
    push(K_DONE, c0);
    push(K_FALL, fall_at);
  endtask

  task automatic wait_until(input int s, input int k);
    int  ts;
    int  tk;
    bit  hit;
    hit = 1'b0;
    for (int n = 0; n < 60000 && !hit; n++) begin
      tnow(ts, tk);
      if (ts == s && tk == k) hit = 1'b1;
      else tick();
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_%0d_%0d: timed out at cyc %0d, required time not reached", s, k, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic req(input int s, input int k);
    sched_valid     = 1'b1;
    sched_utc_sec   = UW'(s);
    sched_clk_count = CW'(k);
    tick();
    sched_valid     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx"},     int'(tx_trigger),  0);
    chk({tag, "_done"},   int'(done),        0);
    chk({tag, "_missed"}, int'(missed),      0);
    chk({tag, "_rej"},    int'(rejected),    0);
    chk({tag, "_armed"},  int'(armed),       0);
    chk({tag, "_synced"}, int'(synced),      0);
    chk({tag, "_ready"},  int'(sched_ready), 0);
  endtask

  // PPS source: 5-cycle high pulse every NOM cycles up to pps_last
  initial begin
    pps = 1'b0;
    forever begin
      tick();
      if (cyc >= pps_base - 3 && ((cyc - pps_base + 3) % NOM) == 0 &&
          ((cyc - pps_base + 3) / NOM) <= pps_last) begin
        pps_hold = 5;
      end
      if (pps_hold > 0) begin
        pps = 1'b1;
        pps_hold--;
      end else begin
        pps = 1'b0;
      end
    end
  end

  // Monitor: every observed output event is matched against the scoreboard
  task automatic sb_check(input int kind);
    ev_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_%s: got event at cyc %0d expected no event", kname(kind), cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_%s: got %s at cyc %0d expected %s at cyc %0d",
                 kname(kind), kname(kind), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  initial begin
    logic prev_tx;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trigger === 1'b1 && prev_tx !== 1'b1) sb_check(K_TRIG);
      if (done === 1'b1) sb_check(K_DONE);
      if (tx_trigger !== 1'b1 && prev_tx === 1'b1) sb_check(K_FALL);
      if (missed === 1'b1) sb_check(K_MISS);
      if (rejected === 1'b1) sb_check(K_REJ);
      prev_tx = tx_trigger;
    end
  end

  initial begin
    int c;
    int x;
    rst_n           = 1'b0;
    gps_utc_sec     = UW'(7);
    sched_valid     = 1'b0;
    sched_utc_sec   = '0;
    sched_clk_count = '0;
    cancel          = 1'b0;

    tick();
    tick();
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    wait_cyc(12);
    chk("pre_pps_synced", int'(synced), 0);

    // Started but not aligned: a request must be ignored
    wait_until(7, 50);
    chk("pre_align_ready",  int'(sched_ready), 0);
    chk("pre_align_synced", int'(synced), 0);
    req(8, 250);
    chk("pre_align_armed", int'(armed), 0);

    // Alignment happens on the cnt==100 cycle
    wait_until(7, 100);
    chk("align_cnt100_synced", int'(synced), 0);
    tick();
    chk("align_cnt101_synced", int'(synced), 1);
    chk("align_cnt101_ready",  int'(sched_ready), 1);

    // Align+fire
    wait_until(7, 500);
    c = cyc_of(1, 250) + 1;
    expect_fire(c, c + TRIG);
    req(8, 250);
    chk("fire_armed", int'(armed), 1);
    chk("fire_ready", int'(sched_ready), 0);

    // Target already in the past
    wait_until(8, 600);
    push(K_MISS, cyc + 1);
    req(8, 300);
    tick();
    chk("missed_ready", int'(sched_ready), 1);
    chk("missed_armed", int'(armed), 0);

    // Cancel
    wait_until(9, 20);
    req(9, 900);
    chk("cancel_armed", int'(armed), 1);
    wait_until(9, 100);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_ready", int'(sched_ready), 1);
    chk("cancel_armed_off", int'(armed), 0);

    // Out-of-range requests
    wait_until(9, 200);
    push(K_REJ, cyc + 1);
    req(60, 0);
    chk("rej_sec_armed", int'(armed), 0);
    chk("rej_sec_ready", int'(sched_ready), 1);
    wait_until(9, 210);
    push(K_REJ, cyc + 1);
    req(9, NOM);
    chk("rej_cnt_armed", int'(armed), 0);

    // Last count of the second coinciding with the PPS edge
    wait_until(9, 220);
    c = cyc_of(2, 999) + 1;
    expect_fire(c, c + TRIG);
    req(9, 999);

    // Wrap 58 -> 59 -> 0 -> 1
    wait_until(58, 100);
    c = cyc_of(54, 10) + 1;
    expect_fire(c, c + TRIG);
    req(1, 10);

    // PPS stops after sec 1; sec 2 is fabricated and starts at cnt 5
    wait_until(1, 900);
    x = cyc_of(55, 500) + 1;
    expect_fire(x, x + 2);
    req(2, 500);
    wait_until(2, 5);
    chk("fab_synced", int'(synced), 1);
    chk("fab_armed", int'(armed), 1);

    // Reset in the middle of the trigger pulse
    wait_cyc(x + 1);
    chk("fire_mid_tx", int'(tx_trigger), 1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_synced", int'(synced), 0);
    chk("post_reset_ready",  int'(sched_ready), 0);

    pps_last = 100;
    pps_base = cyc + 20;
    wait_cyc(pps_base + 50);
    chk("resync_cnt50_ready", int'(sched_ready), 0);
    wait_cyc(pps_base + 100);
    chk("resync_cnt100_synced", int'(synced), 0);
    tick();
    chk("resync_cnt101_synced", int'(synced), 1);
    chk("resync_cnt101_ready",  int'(sched_ready), 1);

    tick();
    tick();
    chk("sb_leftover", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
